// File: rtl/mdu_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer:
// ALU function codes, operation encodings and FSM state encoding.
package mdu_pkg;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00110;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP_A,
        ST_PREP_B,
        ST_ITER,
        ST_FIX1,
        ST_FIX2,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Pipeline-side bundle of the MDU: op launch/abort, MTHI/MTLO writes,
// status and the architectural HI/LO registers.
interface mdu_sequencer_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs, rt, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit that borrows the shared EX-stage ALU
// for every add/subtract; holds the architectural HI/LO registers.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave bus,
    output logic           alu_own,
    output logic [4:0]     alu_conf,
    output logic [5:0]     alu_opcode,
    output logic           alu_sign,
    output logic [31:0]    alu_in1,
    output logic [31:0]    alu_in2,
    input  logic [31:0]    alu_result
);

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] a_reg;   // multiplicand / divisor magnitude
    logic [31:0] x_reg;   // P_hi / remainder
    logic [31:0] y_reg;   // P_lo / quotient
    logic        is_div, neg_res, neg_rem;
    logic        busy_r, done_r;
    logic [31:0] hi_r, lo_r;

    logic [31:0] r_shift;
    logic        carry, ge, neg_b, start_signed, start_div;

    assign alu_opcode = '0;
    assign alu_sign   = 1'b0;
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.hi     = hi_r;
    assign bus.lo     = lo_r;

    assign r_shift      = {x_reg[30:0], y_reg[31]};
    assign carry        = alu_result < x_reg;
    assign ge           = x_reg[31] | (r_shift >= a_reg);
    assign neg_b        = neg_res ^ neg_rem;
    assign start_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign start_div    = (bus.op == OP_DIVU) || (bus.op == OP_DIV);

    always_comb begin
        alu_conf = ALU_ADD;
        alu_in1  = '0;
        alu_in2  = '0;
        case (state)
            ST_PREP_A: begin
                if (neg_rem) begin alu_conf = ALU_SUB; alu_in2 = x_reg; end
                else         alu_in1 = x_reg;
            end
            ST_PREP_B: begin
                if (neg_b) begin alu_conf = ALU_SUB; alu_in2 = y_reg; end
                else       alu_in1 = y_reg;
            end
            ST_ITER: begin
                if (is_div) begin
                    alu_conf = ALU_SUB;
                    alu_in1  = r_shift;
                    alu_in2  = a_reg;
                end else begin
                    alu_in1 = x_reg;
                    alu_in2 = y_reg[0] ? a_reg : '0;
                end
            end
            ST_FIX1: begin
                if (neg_res) begin alu_conf = ALU_SUB; alu_in2 = y_reg; end
                else         alu_in1 = y_reg;
            end
            ST_FIX2: begin
                if (is_div) begin
                    if (neg_rem) begin alu_conf = ALU_SUB; alu_in2 = x_reg; end
                    else         alu_in1 = x_reg;
                end else if (neg_res) begin
                    // y_reg already negated in FIX1; zero stays zero, so the borrow test holds
                    alu_in1 = ~x_reg;
                    alu_in2 = {31'b0, (y_reg == '0)};
                end else begin
                    alu_in1 = x_reg;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_reg   <= '0;
            x_reg   <= '0;
            y_reg   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            alu_own <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else if (state != ST_IDLE && bus.flush) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            alu_own <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        is_div  <= start_div;
                        neg_rem <= start_signed & bus.rs[31];
                        neg_res <= start_signed & (bus.rs[31] ^ bus.rt[31]);
                        x_reg   <= bus.rs;
                        y_reg   <= bus.rt;
                        cnt     <= '0;
                        alu_own <= 1'b1;
                        if (start_div && bus.rt == '0) begin
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                            hi_r   <= bus.rs;
                            lo_r   <= DIV0_LO;
                        end else begin
                            state  <= ST_PREP_A;
                            busy_r <= 1'b1;
                        end
                    end
                end
                ST_PREP_A: begin
                    x_reg <= alu_result;
                    state <= ST_PREP_B;
                end
                ST_PREP_B: begin
                    if (is_div) begin
                        a_reg <= alu_result;
                        y_reg <= x_reg;
                    end else begin
                        a_reg <= x_reg;
                        y_reg <= alu_result;
                    end
                    x_reg <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    if (is_div) begin
                        x_reg <= ge ? alu_result : r_shift;
                        y_reg <= {y_reg[30:0], ge};
                    end else begin
                        x_reg <= {carry, alu_result[31:1]};
                        y_reg <= {alu_result[0], y_reg[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= ST_FIX1;
                end
                ST_FIX1: begin
                    y_reg <= alu_result;
                    state <= ST_FIX2;
                end
                ST_FIX2: begin
                    hi_r   <= alu_result;
                    lo_r   <= y_reg;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    alu_own <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: external ALU model, arithmetic
// reference model, directed scenarios and randomized operations.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_own, alu_sign;
    logic [4:0]  alu_conf;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_in1, alu_in2, alu_result;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mdu_sequencer_if bus();

    mdu_sequencer #(.DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .alu_own    (alu_own),
        .alu_conf   (alu_conf),
        .alu_opcode (alu_opcode),
        .alu_sign   (alu_sign),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    assign alu_result = (alu_conf == ALU_SUB) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] rh, output logic [31:0] rl);
        logic signed [63:0] sa, sb, t;
        logic [63:0] u;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        rh = '0;
        rl = '0;
        if (o == OP_MULTU) begin
            u = {32'b0, a} * {32'b0, b};
            rh = u[63:32];
            rl = u[31:0];
        end else if (o == OP_MULT) begin
            t = sa * sb;
            rh = t[63:32];
            rl = t[31:0];
        end else if (b == '0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else if (o == OP_DIVU) begin
            rl = a / b;
            rh = a % b;
        end else begin
            t = sa / sb;
            rl = t[31:0];
            t = sa % sb;
            rh = t[31:0];
        end
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit mt);
        logic [31:0] rh, rl;
        int lat;
        bit prof_ok, hold_ok, dz;
        ref_model(o, a, b, rh, rl);
        dz = o[1] && (b == '0);
        bus.start = 1'b1;
        bus.op = o;
        bus.rs = a;
        bus.rt = b;
        if (mt) begin
            bus.hi_we = 1'b1;
            bus.lo_we = 1'b1;
            bus.wdata = $urandom;
            exp_hi = bus.wdata;
            exp_lo = bus.wdata;
        end
        @(negedge clk);
        bus.rs = $urandom;
        bus.rt = $urandom;
        bus.op = 2'($urandom);
        lat = 0;
        prof_ok = 1'b1;
        hold_ok = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            bus.start = 1'b0;
            bus.hi_we = 1'b0;
            bus.lo_we = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
            if (bus.busy !== 1'b1 || alu_own !== 1'b1 || alu_opcode !== 6'h00 || alu_sign !== 1'b0)
                prof_ok = 1'b0;
            if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_ok = 1'b0;
            if (c == 5) begin bus.start = 1'b1; bus.op = 2'($urandom); end
            if (c == 8) begin bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = $urandom; end
        end
        check("latency", 32'(lat), dz ? 32'd1 : 32'd37);
        check("busy/own profile", {31'b0, prof_ok}, 32'd1);
        check("hi/lo hold mid-op", {31'b0, hold_ok}, 32'd1);
        check("hi result", bus.hi, rh);
        check("lo result", bus.lo, rl);
        check("busy at done", {31'b0, bus.busy}, 32'd0);
        check("alu_own at done", {31'b0, alu_own}, 32'd1);
        exp_hi = rh;
        exp_lo = rl;
        bus.start = 1'b1;
        bus.op = 2'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
        check("done single pulse", {31'b0, bus.done}, 32'd0);
        check("idle alu_own", {31'b0, alu_own}, 32'd0);
        check("idle alu_conf", {27'b0, alu_conf}, 32'd0);
        check("idle alu_in1", alu_in1, 32'd0);
        check("idle alu_in2", alu_in2, 32'd0);
        check("idle hi", bus.hi, exp_hi);
        check("idle lo", bus.lo, exp_lo);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        bit seen;
        bus.start = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0;
        bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        @(negedge clk);
        check("reset busy", {31'b0, bus.busy}, 32'd0);
        check("reset done", {31'b0, bus.done}, 32'd0);
        check("reset alu_own", {31'b0, alu_own}, 32'd0);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset alu_in1", alu_in1, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu hi const", exp_hi, 32'hFFFF_FFFE);
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
        check("mult lo const", exp_lo, 32'hFFFF_FFEB);
        do_op(OP_DIVU, 32'd7, 32'd2, 1'b0);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div ovf lo const", exp_lo, 32'h8000_0000);
        do_op(OP_DIV, 32'h0000_1234, 32'd0, 1'b0);
        do_op(OP_DIVU, 32'd1000, 32'd0, 1'b1);
        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);

        // flush in IDLE has no effect on an MTLO write
        bus.flush = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_0001;
        @(negedge clk);
        bus.flush = 1'b0; bus.lo_we = 1'b0;
        exp_lo = 32'hCAFE_0001;
        check("flush idle lo write", bus.lo, exp_lo);
        check("flush idle busy", {31'b0, bus.busy}, 32'd0);

        // flush mid-op
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs = 32'h1234_5678; bus.rt = 32'h8765_4321;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            bus.start = (c == 5);
        end
        check("busy before flush", {31'b0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", {31'b0, bus.busy}, 32'd0);
        check("flush alu_own", {31'b0, alu_own}, 32'd0);
        check("flush done", {31'b0, bus.done}, 32'd0);
        check("flush hi", bus.hi, exp_hi);
        check("flush lo", bus.lo, exp_lo);
        seen = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen = 1'b1;
        end
        check("no done after flush", {31'b0, seen}, 32'd0);
        check("flush hi later", bus.hi, exp_hi);

        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = '0;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op(o, a, b, $urandom_range(0, 3) == 0);
        end

        // reset mid-op
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_00AA;
        @(negedge clk);
        bus.hi_we = 1'b0;
        exp_hi = 32'h0000_00AA;
        check("mthi", bus.hi, exp_hi);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs = 32'd100; bus.rt = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("busy before reset", {31'b0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("reset mid busy", {31'b0, bus.busy}, 32'd0);
        check("reset mid hi", bus.hi, 32'd0);
        check("reset mid lo", bus.lo, 32'd0);
        check("reset mid alu_own", {31'b0, alu_own}, 32'd0);
        check("reset mid alu_in1", alu_in1, 32'd0);
        check("reset mid alu_conf", {27'b0, alu_conf}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        do_op(OP_MULTU, 32'd6, 32'd7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
